// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB completer among NUM_REQ local requesters.
// It runs one transfer at a time, returns a response per requester and times out hung ACCESS phases.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif

module apb_req_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_WIDTH  = `APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    output logic [STRB_WIDTH-1:0]         PSTRB,
    input  logic                          PREADY,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PSLVERR
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYC == 0) ? '0 : TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        rr_q, rr_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;

    logic [NUM_REQ-1:0]      grant_d, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d;
    logic                    rsp_err_d;
    logic                    psel_d, penable_d, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_d;

    logic [NUM_REQ-1:0]      cand_c;
    logic                    win_found_c;
    logic [PTR_W-1:0]        win_c;
    logic                    tmo_hit_c;
    logic                    capture_c;

    // Round-robin pick: first candidate at or after rr_q; the current owner is excluded while in ACCESS
    always_comb begin
        int unsigned idx;
        idx         = 0;
        cand_c      = req_valid;
        win_found_c = 1'b0;
        win_c       = '0;
        if (state_q == S_ACCESS) begin
            cand_c[owner_q] = 1'b0;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_q) + i) % NUM_REQ;
            if (!win_found_c && cand_c[PTR_W'(idx)]) begin
                win_found_c = 1'b1;
                win_c       = PTR_W'(idx);
            end
        end
    end

    assign tmo_hit_c = (TIMEOUT_CYC != 0) && (tmo_q == TMO_LAST);

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        tmo_d       = tmo_q;
        grant_d     = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        pstrb_d     = PSTRB;
        capture_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (win_found_c) begin
                    capture_c = 1'b1;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                tmo_d     = '0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                tmo_d = tmo_q + 1'b1;
                if (PREADY) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = PWRITE ? '0 : PRDATA;
                    rsp_err_d            = PSLVERR;
                    if (win_found_c) begin
                        capture_c = 1'b1;
                    end else begin
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end else if (tmo_hit_c) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    state_d              = S_IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // Load the winner's payload onto the bus and open its SETUP phase
        if (capture_c) begin
            grant_d[win_c] = 1'b1;
            owner_d        = win_c;
            rr_d           = (32'(win_c) == NUM_REQ - 1) ? '0 : PTR_W'(32'(win_c) + 1);
            psel_d         = 1'b1;
            penable_d      = 1'b0;
            pwrite_d       = req_write[win_c];
            paddr_d        = req_addr[32'(win_c)*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata_d       = req_wdata[32'(win_c)*DATA_WIDTH +: DATA_WIDTH];
            pstrb_d        = req_write[win_c] ? req_strb[32'(win_c)*STRB_WIDTH +: STRB_WIDTH] : '0;
            tmo_d          = '0;
            state_d        = S_SETUP;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            owner_q   <= '0;
            tmo_q     <= '0;
            req_grant <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            tmo_q     <= tmo_d;
            req_grant <= grant_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            PSTRB     <= pstrb_d;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small APB memory completer model
// that supports wait states, an error address and a hang mode.
module tb_apb_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = 4;

    logic              PCLK;
    logic              PRESETn;
    logic [NR-1:0]     req_valid, req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*SW-1:0]  req_strb;
    logic [NR-1:0]     req_grant, rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              PSEL, PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [SW-1:0]     PSTRB;
    logic              PREADY;
    logic [DW-1:0]     PRDATA;
    logic              PSLVERR;

    logic [31:0]       mem [0:255];
    logic              ld_en;
    logic [7:0]        ld_addr;
    logic [31:0]       ld_data;
    int                acc_cnt;
    int                wait_st;
    int                checks;
    int                passed;

    apb_req_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYC(8)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Completer: ready after wait_st ACCESS cycles, error at address 0x005, fixed pattern on write reads
    assign PREADY  = PSEL && PENABLE && (acc_cnt >= wait_st);
    assign PRDATA  = PWRITE ? 32'hA5A5_A5A5 : mem[PADDR[7:0]];
    assign PSLVERR = PSEL && PENABLE && (PADDR == 12'h005);

    always @(posedge PCLK) begin
        if (!PRESETn) begin
            for (int k = 0; k < 256; k++) mem[k] <= '0;
            acc_cnt <= 0;
        end else begin
            if (ld_en) begin
                mem[ld_addr] <= ld_data;
            end else if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) begin
                for (int b = 0; b < 4; b++)
                    if (PSTRB[b]) mem[PADDR[7:0]][b*8 +: 8] <= PWDATA[b*8 +: 8];
            end
            acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
        end
    end

    // Advance to the next falling edge; granted requesters withdraw their request
    task automatic step();
        @(negedge PCLK);
        req_valid = req_valid & ~req_grant;
    endtask

    task automatic issue(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_valid[i]          = 1'b1;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW]  = s;
    endtask

    task automatic mem_load(input logic [7:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; req_strb = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; wait_st = 0;
        step(); step();
        checks++; if ({PSEL, PENABLE, PWRITE, rsp_err} !== 4'b0) $display("FAIL reset_ctrl: got %b exp 0000", {PSEL, PENABLE, PWRITE, rsp_err}); else passed++;
        checks++; if ({req_grant, rsp_valid} !== 8'h00) $display("FAIL reset_pulses: got %h exp 00", {req_grant, rsp_valid}); else passed++;
        checks++; if ({PADDR, PWDATA, PSTRB, rsp_rdata} !== '0) $display("FAIL reset_data: got %h exp 0", {PADDR, PWDATA, PSTRB, rsp_rdata}); else passed++;
        PRESETn = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        mem_load(8'h20, 32'hDEAD_BEEF);
        issue(0, 1'b0, 12'h020, 32'h0, 4'hF);
        step();
        checks++; if ({PSEL, PENABLE} !== 2'b10) $display("FAIL rd_setup: got %b exp 10", {PSEL, PENABLE}); else passed++;
        checks++; if (req_grant !== 4'b0001) $display("FAIL rd_grant: got %b exp 0001", req_grant); else passed++;
        checks++; if ({PWRITE, PADDR, PSTRB} !== {1'b0, 12'h020, 4'h0}) $display("FAIL rd_bus: got %h exp 00200", {PWRITE, PADDR, PSTRB}); else passed++;
        step();
        checks++; if ({PSEL, PENABLE, rsp_valid} !== 6'b11_0000) $display("FAIL rd_access: got %b exp 110000", {PSEL, PENABLE, rsp_valid}); else passed++;
        step();
        checks++; if (rsp_valid !== 4'b0001) $display("FAIL rd_rspv: got %b exp 0001", rsp_valid); else passed++;
        checks++; if ({rsp_rdata, rsp_err} !== {32'hDEAD_BEEF, 1'b0}) $display("FAIL rd_data: got %h/%b exp deadbeef/0", rsp_rdata, rsp_err); else passed++;
        checks++; if ({PSEL, PENABLE} !== 2'b00) $display("FAIL rd_idle: got %b exp 00", {PSEL, PENABLE}); else passed++;
    endtask

    task automatic test_write_strobe();
        issue(1, 1'b1, 12'h040, 32'h1234_5678, 4'b0011);
        step();
        checks++; if (req_grant !== 4'b0010) $display("FAIL wr_grant: got %b exp 0010", req_grant); else passed++;
        checks++; if ({PWRITE, PWDATA, PSTRB} !== {1'b1, 32'h1234_5678, 4'b0011}) $display("FAIL wr_bus: got %h exp 1123456783", {PWRITE, PWDATA, PSTRB}); else passed++;
        step();
        step();
        checks++; if ({rsp_valid, rsp_rdata, rsp_err} !== {4'b0010, 32'h0, 1'b0}) $display("FAIL wr_rsp: got %h exp 0010/0/0", {rsp_valid, rsp_rdata, rsp_err}); else passed++;
        issue(1, 1'b0, 12'h040, 32'h0, 4'hF);
        step();
        checks++; if ({req_grant, PSTRB} !== {4'b0010, 4'h0}) $display("FAIL rb_strb: got %b exp 00100000", {req_grant, PSTRB}); else passed++;
        step();
        step();
        checks++; if ({rsp_valid, rsp_rdata} !== {4'b0010, 32'h0000_5678}) $display("FAIL rb_data: got %h exp 2_00005678", {rsp_valid, rsp_rdata}); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] dat [4];
        logic [11:0] adr [4];
        logic [3:0]  exp_rsp;
        PRESETn = 1'b0; step(); PRESETn = 1'b1; step();
        for (int k = 0; k < 4; k++) begin
            adr[k] = 12'h060 + 12'(4 * k);
            dat[k] = 32'h1111_0000 + 32'(k);
            mem_load(adr[k][7:0], dat[k]);
        end
        for (int k = 0; k < 4; k++) issue(k, 1'b0, adr[k], 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            exp_rsp = (k == 0) ? 4'b0000 : 4'(1 << (k - 1));
            checks++; if ({req_grant, PSEL, PENABLE} !== {4'(1 << k), 2'b10}) $display("FAIL b2b_setup%0d: got %b exp %b", k, {req_grant, PSEL, PENABLE}, {4'(1 << k), 2'b10}); else passed++;
            checks++; if ({rsp_valid, PADDR} !== {exp_rsp, adr[k]}) $display("FAIL b2b_rsp%0d: got %h exp %h", k, {rsp_valid, PADDR}, {exp_rsp, adr[k]}); else passed++;
            if (k > 0) begin
                checks++; if (rsp_rdata !== dat[k-1]) $display("FAIL b2b_data%0d: got %h exp %h", k, rsp_rdata, dat[k-1]); else passed++;
            end
            step();
            checks++; if ({PSEL, PENABLE} !== 2'b11) $display("FAIL b2b_access%0d: got %b exp 11", k, {PSEL, PENABLE}); else passed++;
        end
        step();
        checks++; if ({rsp_valid, rsp_rdata, PSEL} !== {4'b1000, dat[3], 1'b0}) $display("FAIL b2b_last: got %h exp %h", {rsp_valid, rsp_rdata, PSEL}, {4'b1000, dat[3], 1'b0}); else passed++;
    endtask

    task automatic test_slverr();
        issue(2, 1'b1, 12'h005, 32'hCAFE_F00D, 4'hF);
        step();
        checks++; if (req_grant !== 4'b0100) $display("FAIL err_grant: got %b exp 0100", req_grant); else passed++;
        step();
        step();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0100, 1'b1, 32'h0}) $display("FAIL err_rsp: got %h exp 4_1_00000000", {rsp_valid, rsp_err, rsp_rdata}); else passed++;
        issue(0, 1'b0, 12'h060, 32'h0, 4'h0);
        step();
        checks++; if (req_grant !== 4'b0001) $display("FAIL err_next_grant: got %b exp 0001", req_grant); else passed++;
        step();
        step();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0001, 1'b0, 32'h1111_0000}) $display("FAIL err_next_rsp: got %h exp 1_0_11110000", {rsp_valid, rsp_err, rsp_rdata}); else passed++;
    endtask

    task automatic test_timeout();
        wait_st = 255;
        issue(1, 1'b0, 12'h064, 32'h0, 4'h0);
        step();
        checks++; if (req_grant !== 4'b0010) $display("FAIL to_grant: got %b exp 0010", req_grant); else passed++;
        issue(3, 1'b0, 12'h068, 32'h0, 4'h0);
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++; if ({PSEL, PENABLE, rsp_valid} !== 6'b11_0000) $display("FAIL to_wait%0d: got %b exp 110000", k, {PSEL, PENABLE, rsp_valid}); else passed++;
        end
        step();
        checks++; if ({PSEL, PENABLE, req_grant} !== 6'b00_0000) $display("FAIL to_drop: got %b exp 000000", {PSEL, PENABLE, req_grant}); else passed++;
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0010, 1'b1, 32'h0}) $display("FAIL to_rsp: got %h exp 2_1_00000000", {rsp_valid, rsp_err, rsp_rdata}); else passed++;
        wait_st = 0;
        step();
        checks++; if ({req_grant, PSEL, PENABLE} !== 6'b1000_10) $display("FAIL to_after_grant: got %b exp 100010", {req_grant, PSEL, PENABLE}); else passed++;
        step();
        step();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b1000, 1'b0, 32'h1111_0002}) $display("FAIL to_after_rsp: got %h exp 8_0_11110002", {rsp_valid, rsp_err, rsp_rdata}); else passed++;
    endtask

    task automatic test_pready_vs_timeout();
        wait_st = 7;
        issue(2, 1'b0, 12'h06C, 32'h0, 4'h0);
        step();
        checks++; if (req_grant !== 4'b0100) $display("FAIL rvt_grant: got %b exp 0100", req_grant); else passed++;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++; if ({PSEL, PENABLE, rsp_valid} !== 6'b11_0000) $display("FAIL rvt_wait%0d: got %b exp 110000", k, {PSEL, PENABLE, rsp_valid}); else passed++;
        end
        step();
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0100, 1'b0, 32'h1111_0003}) $display("FAIL rvt_rsp: got %h exp 4_0_11110003", {rsp_valid, rsp_err, rsp_rdata}); else passed++;
        wait_st = 0;
    endtask

    task automatic test_reset_mid();
        wait_st = 255;
        issue(3, 1'b0, 12'h068, 32'h0, 4'h0);
        step();
        checks++; if (req_grant !== 4'b1000) $display("FAIL rst_grant: got %b exp 1000", req_grant); else passed++;
        step();
        checks++; if ({PSEL, PENABLE} !== 2'b11) $display("FAIL rst_access: got %b exp 11", {PSEL, PENABLE}); else passed++;
        #2 PRESETn = 1'b0;
        #1;
        checks++; if ({PSEL, PENABLE, PWRITE, req_grant, rsp_valid} !== 11'b0) $display("FAIL rst_async: got %b exp 0", {PSEL, PENABLE, PWRITE, req_grant, rsp_valid}); else passed++;
        checks++; if ({PADDR, PSTRB, rsp_rdata, rsp_err} !== '0) $display("FAIL rst_async_data: got %h exp 0", {PADDR, PSTRB, rsp_rdata, rsp_err}); else passed++;
        req_valid = '0;
        step();
        step();
        PRESETn = 1'b1;
        wait_st = 0;
        step();
        checks++; if ({rsp_valid, PSEL} !== 5'b0) $display("FAIL rst_no_rsp: got %b exp 00000", {rsp_valid, PSEL}); else passed++;
        issue(2, 1'b0, 12'h010, 32'h0, 4'h0);
        issue(1, 1'b0, 12'h014, 32'h0, 4'h0);
        issue(0, 1'b0, 12'h018, 32'h0, 4'h0);
        step();
        checks++; if ({req_grant, PADDR} !== {4'b0001, 12'h018}) $display("FAIL rst_rr_ptr: got %h exp 1018", {req_grant, PADDR}); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_single_read();
        test_write_strobe();
        test_back_to_back();
        test_slverr();
        test_timeout();
        test_pready_vs_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
